mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/params_pkg.sv | 7 +
 rtl/mem_resp_array.sv | 28 ++
 rtl/mem_responder.sv | 88 ++++++++
 tb/tb_mem_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// params_pkg: shared memory-system parameters and the access size type.
package params_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int CACHE_LINE_BYTES = 16;
    localparam int MEM_SIZE = 4096;
    typedef enum logic [1:0] {SZ_BYTE, SZ_WORD, SZ_LINE} access_size_t;
endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: byte store with one line read port and one byte-enable line write port, indices wrap modulo MEM_SIZE.
module mem_resp_array #(
    parameter int MEM_SIZE = 4096,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16
)(
    input  logic                    clk,
    input  logic [ADDR_WIDTH-1:0]   base,
    input  logic                    we,
    input  logic [LINE_BYTES-1:0]   be,
    input  logic [8*LINE_BYTES-1:0] wr_line,
    output logic [8*LINE_BYTES-1:0] rd_line
);
    localparam int IW = $clog2(MEM_SIZE);
    logic [7:0] mem [MEM_SIZE];
    function automatic logic [IW-1:0] idx(input logic [ADDR_WIDTH-1:0] a, input int i);
        logic [ADDR_WIDTH:0] s;
        s = {1'b0, a} + (ADDR_WIDTH+1)'(i);
        return IW'(s % (ADDR_WIDTH+1)'(MEM_SIZE));
    endfunction
    always_comb begin
        rd_line = '0;
        for (int i = 0; i < LINE_BYTES; i++) rd_line[8*i +: 8] = mem[idx(base, i)];
    end
    always_ff @(posedge clk)
        for (int i = 0; i < LINE_BYTES; i++)
            if (we && be[i]) mem[idx(base, i)] <= wr_line[8*i +: 8];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder (IDLE->WAIT->RESP); define MEM_RESP_RANGE_CHECK_EN to zero/drop out-of-range lines instead of wrapping.
module mem_responder
    import params_pkg::access_size_t, params_pkg::SZ_WORD, params_pkg::SZ_LINE;
#(
    parameter int MEM_SIZE = params_pkg::MEM_SIZE,
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = 8 * params_pkg::CACHE_LINE_BYTES,
    parameter int MEM_LATENCY = 4
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_req_valid_i,
    input  logic                  wr_req_valid_i,
    input  logic                  req_is_instr_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  access_size_t          access_size_i,
    output logic                  data_valid_o,
    output logic                  data_is_instr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  write_done_o,
    output logic                  busy_o
);
    localparam int LINE_BYTES = DATA_WIDTH / 8;
    localparam int LBW = $clog2(LINE_BYTES);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [ADDR_WIDTH-1:0] addr_q, base;
    logic [DATA_WIDTH-1:0] wdata_q, wr_line, rd_line;
    access_size_t size_q;
    logic wr_q, instr_q, accept, commit, oor;
    logic [LBW-1:0] off, woff;
    logic [LINE_BYTES-1:0] be;
    assign accept = state == IDLE && (rd_req_valid_i || wr_req_valid_i);
    assign commit = state == WAIT && cnt == '0;
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state == IDLE ? (accept ? WAIT : IDLE) : state == WAIT ? (cnt == '0 ? RESP : WAIT) : IDLE;
        busy_o = state != IDLE;
        data_valid_o = state == RESP && !wr_q;
        write_done_o = state == RESP && wr_q;
        data_is_instr_o = data_valid_o && instr_q;
    end
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            cnt <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            size_q <= access_size_t'('0);
            wr_q <= 1'b0;
            instr_q <= 1'b0;
            data_o <= '0;
        end else begin
            if (accept) begin
                cnt <= 4'(MEM_LATENCY - 1);
                addr_q <= address_i;
                wdata_q <= wr_data_i;
                size_q <= access_size_i;
                wr_q <= wr_req_valid_i;
                instr_q <= req_is_instr_i;
            end else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (commit && !wr_q) data_o <= oor ? '0 : rd_line;
        end
    // Sub-line writes are shifted into place within the aligned line and masked by byte enables.
    assign base = addr_q & ~ADDR_WIDTH'(LINE_BYTES - 1);
    assign off = addr_q[LBW-1:0];
    assign woff = {off[LBW-1:2], 2'b00};
    assign be = size_q == SZ_LINE ? '1 : size_q == SZ_WORD ? LINE_BYTES'(4'hF) << woff : LINE_BYTES'(1'b1) << off;
    assign wr_line = size_q == SZ_LINE ? wdata_q
                   : size_q == SZ_WORD ? DATA_WIDTH'(wdata_q[31:0]) << {woff, 3'b000}
                   : DATA_WIDTH'(wdata_q[7:0]) << {off, 3'b000};
`ifdef MEM_RESP_RANGE_CHECK_EN
    assign oor = ({1'b0, base} + (ADDR_WIDTH+1)'(LINE_BYTES)) > (ADDR_WIDTH+1)'(MEM_SIZE);
`else
    assign oor = 1'b0;
`endif
    mem_resp_array #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .LINE_BYTES(LINE_BYTES)) u_array (
        .clk(clk_i),
        .base(base),
        .we(commit && wr_q && !oor),
        .be(be),
        .wr_line(wr_line),
        .rd_line(rd_line)
    );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed requests with a byte-level reference memory feeding an expected-response queue.
module tb_mem_responder;
    import params_pkg::*;
    localparam int LAT = 4;
    logic clk_i = 1'b0, rst_i = 1'b0;
    logic rd_req_valid_i = 1'b0, wr_req_valid_i = 1'b0, req_is_instr_i = 1'b0;
    logic [31:0] address_i = '0;
    logic [127:0] wr_data_i = '0;
    access_size_t access_size_i = SZ_BYTE;
    logic data_valid_o, data_is_instr_o, write_done_o, busy_o;
    logic [127:0] data_o;
    typedef struct packed {logic is_wr; logic [127:0] data; logic instr;} exp_t;
    exp_t sb[$];
    logic [7:0] ref_mem [4096];
    int checks = 0, failures = 0;
    always #5 clk_i = ~clk_i;
    mem_responder #(.MEM_SIZE(4096), .ADDR_WIDTH(32), .DATA_WIDTH(128), .MEM_LATENCY(LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_req_valid_i(rd_req_valid_i), .wr_req_valid_i(wr_req_valid_i),
        .req_is_instr_i(req_is_instr_i), .address_i(address_i),
        .wr_data_i(wr_data_i), .access_size_i(access_size_i),
        .data_valid_o(data_valid_o), .data_is_instr_o(data_is_instr_o),
        .data_o(data_o), .write_done_o(write_done_o), .busy_o(busy_o)
    );
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [127:0] model_line(input logic [31:0] a);
        logic [127:0] r;
        logic [31:0] b;
        b = a & ~32'hF;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_mem[(b + 32'(i)) % 32'd4096];
`ifdef MEM_RESP_RANGE_CHECK_EN
        if (b + 32'd16 > 32'd4096) r = '0;
`endif
        return r;
    endfunction
    function automatic void model_write(input logic [31:0] a, input logic [127:0] d, input access_size_t sz);
        logic [31:0] b;
        int n;
        b = sz == SZ_LINE ? a & ~32'hF : sz == SZ_WORD ? a & ~32'h3 : a;
        n = sz == SZ_LINE ? 16 : sz == SZ_WORD ? 4 : 1;
`ifdef MEM_RESP_RANGE_CHECK_EN
        if ((a & ~32'hF) + 32'd16 > 32'd4096) return;
`endif
        for (int i = 0; i < n; i++) ref_mem[(b + 32'(i)) % 32'd4096] = d[8*i +: 8];
    endfunction
    task automatic drop();
        rd_req_valid_i = 1'b0;
        wr_req_valid_i = 1'b0;
    endtask
    task automatic issue(input logic rd, input logic wr, input logic instr, input logic [31:0] a,
                         input logic [127:0] wd, input access_size_t sz, input bit hold);
        exp_t e;
        int n;
        @(negedge clk_i);
        rd_req_valid_i = rd;
        wr_req_valid_i = wr;
        req_is_instr_i = instr;
        address_i = a;
        wr_data_i = wd;
        access_size_i = sz;
        if (wr) begin
            model_write(a, wd, sz);
            sb.push_back(exp_t'{is_wr: 1'b1, data: '0, instr: 1'b0});
        end else sb.push_back(exp_t'{is_wr: 1'b0, data: model_line(a), instr: instr});
        @(posedge clk_i); #1;
        chk("busy_on", busy_o, 1);
        if (!hold) drop();
        n = 0;
        while (n < 20 && !(data_valid_o || write_done_o)) begin
            @(posedge clk_i); #1;
            n++;
        end
        drop();
        e = sb.pop_front();
        chk("latency", n, LAT);
        chk("kind", {write_done_o, data_valid_o}, e.is_wr ? 2'b10 : 2'b01);
        if (!e.is_wr) begin
            chk("rd_data", data_o, e.data);
            chk("instr_tag", data_is_instr_o, e.instr);
        end
        @(posedge clk_i); #1;
        chk("pulse_off", {write_done_o, data_valid_o}, 0);
        chk("busy_off", busy_o, 0);
        if (!e.is_wr) chk("data_hold", data_o, e.data);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        logic seen;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", data_valid_o, 0);
        chk("rst_wdone", write_done_o, 0);
        chk("rst_instr", data_is_instr_o, 0);
        chk("rst_data", data_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        // line at 0x0, then instruction fetch of it
        issue(0, 1, 0, 32'h0, 128'h0123456789ABCDEF_FEDCBA9876543210, SZ_LINE, 0);
        issue(1, 0, 1, 32'h0, '0, SZ_LINE, 0);
        // line write to 0x40 read back via an unaligned address
        issue(0, 1, 0, 32'h40, 128'h0F0E0D0C0B0A0908_0706050403020100, SZ_LINE, 0);
        issue(1, 0, 0, 32'h44, '0, SZ_LINE, 0);
        chk("line_0x40", data_o, 128'h0F0E0D0C0B0A0908_0706050403020100);
        // word then byte merge inside a cleared line
        issue(0, 1, 0, 32'h20, '0, SZ_LINE, 0);
        issue(0, 1, 0, 32'h22, 128'hDEADBEEF, SZ_WORD, 0);
        issue(0, 1, 0, 32'h21, 128'h55, SZ_BYTE, 0);
        issue(1, 0, 0, 32'h20, '0, SZ_LINE, 0);
        chk("word_merge", data_o[63:0], 64'h00000000_DEAD55EF);
        // simultaneous rd+wr held through busy: write wins, nothing re-issued
        issue(1, 1, 0, 32'h80, 128'hCAFEF00D_11223344_55667788_99AABBCC, SZ_LINE, 1);
        seen = 1'b0;
        repeat (LAT + 2) begin
            @(posedge clk_i); #1;
            seen = seen | data_valid_o | write_done_o | busy_o;
        end
        chk("no_requeue", seen, 0);
        issue(1, 0, 0, 32'h80, '0, SZ_LINE, 0);
        // reset two cycles into a write aborts it
        issue(0, 1, 0, 32'h60, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222, SZ_LINE, 0);
        @(negedge clk_i);
        wr_req_valid_i = 1'b1;
        address_i = 32'h60;
        wr_data_i = 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;
        access_size_i = SZ_LINE;
        @(posedge clk_i); #1;
        drop();
        @(posedge clk_i);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_data", data_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        seen = 1'b0;
        repeat (LAT + 4) begin
            @(posedge clk_i); #1;
            seen = seen | data_valid_o | write_done_o;
        end
        chk("abort_quiet", seen, 0);
        issue(1, 0, 0, 32'h60, '0, SZ_LINE, 0);
        // read past the end: zeros with range check, wrapped line 0x0 without
        issue(1, 0, 0, 32'd4096, '0, SZ_LINE, 0);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
